// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of a 16-bit single-port
// memory with registered read data. Port A (CPU) and port B (loader/debug DMA)
// are serialised through a three-state sequence IDLE -> ISSUE -> RESP.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// on simultaneous requests; without it, port A has fixed priority.
module mem_arbiter #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          CLK,
    input  logic          resetn,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t        state_r, state_s;
    logic          owner_r, owner_s;
    logic          last_grant_r, last_grant_s;
    logic          we_r, we_s;
    logic          mem_read_r, mem_read_s;
    logic          mem_write_r, mem_write_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic [DW-1:0] mem_wdata_r, mem_wdata_s;
    logic          a_ack_r, a_ack_s;
    logic          b_ack_r, b_ack_s;
    logic [DW-1:0] a_rdata_r, a_rdata_s;
    logic [DW-1:0] b_rdata_r, b_rdata_s;
    logic          busy_r, busy_s;
    logic          grant_b_s;

    // Arbitration: decide whether port B wins when sampled in IDLE.
    always_comb begin
        grant_b_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (a_req && b_req) begin
            grant_b_s = (last_grant_r == PORT_A);
        end else begin
            grant_b_s = b_req;
        end
`else
        if (a_req) begin
            grant_b_s = 1'b0;
        end else begin
            grant_b_s = b_req;
        end
`endif
    end

    // Next-state and next-output logic of the sequencer; all outputs are registered.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        we_s         = we_r;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        a_ack_s      = 1'b0;
        b_ack_s      = 1'b0;
        a_rdata_s    = a_rdata_r;
        b_rdata_s    = b_rdata_r;
        case (state_r)
            IDLE: begin
                if (a_req || b_req) begin
                    owner_s = grant_b_s ? PORT_B : PORT_A;
                    if (grant_b_s) begin
                        we_s        = b_we;
                        mem_addr_s  = b_addr;
                        mem_wdata_s = b_wdata;
                    end else begin
                        we_s        = a_we;
                        mem_addr_s  = a_addr;
                        mem_wdata_s = a_wdata;
                    end
                    mem_read_s  = ~we_s;
                    mem_write_s = we_s;
                    state_s     = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // Memory samples the strobe at the end of this cycle; the ack
                // register is loaded now so it is high throughout RESP.
                a_ack_s = (owner_r == PORT_A);
                b_ack_s = (owner_r == PORT_B);
                state_s = RESP;
            end
            RESP: begin
                if (!we_r) begin
                    if (owner_r == PORT_A) begin
                        a_rdata_s = mem_rdata;
                    end else begin
                        b_rdata_s = mem_rdata;
                    end
                end else begin
                    a_rdata_s = a_rdata_r;
                    b_rdata_s = b_rdata_r;
                end
                last_grant_s = owner_r;
                state_s      = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_r      <= IDLE;
            owner_r      <= PORT_A;
            last_grant_r <= PORT_B;
            we_r         <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= {AW{1'b0}};
            mem_wdata_r  <= {DW{1'b0}};
            a_ack_r      <= 1'b0;
            b_ack_r      <= 1'b0;
            a_rdata_r    <= {DW{1'b0}};
            b_rdata_r    <= {DW{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            we_r         <= we_s;
            mem_read_r   <= mem_read_s;
            mem_write_r  <= mem_write_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            a_ack_r      <= a_ack_s;
            b_ack_r      <= b_ack_s;
            a_rdata_r    <= a_rdata_s;
            b_rdata_r    <= b_rdata_s;
            busy_r       <= busy_s;
        end
    end

    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign a_ack     = a_ack_r;
    assign b_ack     = b_ack_r;
    assign busy      = busy_r;

    // Memory read data is itself a register and arrives in the ack cycle, so it
    // is forwarded during the ack and held by the capture register afterwards.
    assign a_rdata = (a_ack_r && !we_r) ? mem_rdata : a_rdata_r;
    assign b_rdata = (b_ack_r && !we_r) ? mem_rdata : b_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with a 1024-word
// registered-read memory model. Expected order under arbitration follows
// MEM_ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;

    logic        CLK;
    logic        resetn;
    logic        a_req, a_we, a_ack;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_ack;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic        mem_read, mem_write, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int checks;
    int errors;
    int cyc;
    int last_ack_cyc;
    bit mon_en;

    logic [15:0] mem [0:1023];

    mem_arbiter #(.DW(16), .AW(16)) dut (
        .CLK(CLK), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Cycle counter used to measure ack spacing.
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model: 1024 words, upper address bits ignored, registered read.
    always @(posedge CLK) begin
        if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Exclusivity of strobes and acks every cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            check("excl_strobe", 32'(mem_read & mem_write), 32'd0);
            check("excl_ack", 32'(a_ack & b_ack), 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One complete transaction on port p, starting with the FSM in IDLE.
    task automatic txn(input bit p, input bit we, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_rd, input string tag);
        logic [15:0] other_before;
        if (!p) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
            other_before = b_rdata;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
            other_before = a_rdata;
        end
        tick();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_mrd"}, 32'(mem_read), 32'(!we));
        check({tag, "_mwr"}, 32'(mem_write), 32'(we));
        check({tag, "_maddr"}, 32'(mem_addr), 32'(addr));
        if (we) check({tag, "_mwdata"}, 32'(mem_wdata), 32'(wd));
        tick();
        check({tag, "_strobe_off"}, 32'(mem_read | mem_write), 32'd0);
        check({tag, "_ack"}, 32'(p ? b_ack : a_ack), 32'd1);
        check({tag, "_other_ack"}, 32'(p ? a_ack : b_ack), 32'd0);
        check({tag, "_other_rdata"}, 32'(p ? a_rdata : b_rdata), 32'(other_before));
        if (!we) check({tag, "_rdata"}, 32'(p ? b_rdata : a_rdata), 32'(exp_rd));
        last_ack_cyc = cyc;
        tick();
        if (!p) a_req = 1'b0; else b_req = 1'b0;
        check({tag, "_ack_pulse"}, 32'(a_ack | b_ack), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        if (!we) check({tag, "_rdata_held"}, 32'(p ? b_rdata : a_rdata), 32'(exp_rd));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          exp_w [6];
        int          a_left, b_left, ai, t0;
        checks = 0; errors = 0; cyc = 0; last_ack_cyc = 0; mon_en = 1'b0;
        resetn = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'd5; a_wdata = 16'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 16'd0; b_wdata = 16'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`else
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif

        // Reset held with a_req high.
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({a_ack, b_ack}), 32'd0);
        check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        check("rst_maddr", 32'(mem_addr), 32'd0);
        check("rst_mwdata", 32'(mem_wdata), 32'd0);
        check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        resetn = 1'b1;
        tick();
        check("rel_grant_rd", 32'(mem_read), 32'd1);
        check("rel_grant_addr", 32'(mem_addr), 32'd5);
        tick();
        check("rel_ack", 32'(a_ack), 32'd1);
        tick();
        a_req = 1'b0;
        check("rel_idle", 32'(busy), 32'd0);

        // Port A write then read at 25; upper address bits alias in memory.
        txn(1'b0, 1'b1, 16'd25, 16'h1234, 16'h0000, "a_wr25");
        txn(1'b0, 1'b0, 16'd25, 16'h0000, 16'h1234, "a_rd25");
        txn(1'b0, 1'b1, 16'h0419, 16'h5A5A, 16'h0000, "a_wr_alias");
        txn(1'b0, 1'b0, 16'd25, 16'h0000, 16'h5A5A, "a_rd_alias");
        txn(1'b0, 1'b1, 16'd26, 16'hBEEF, 16'h0000, "a_wr26");

        // Protocol violation: req dropped before ack still completes.
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'd26;
        tick();
        a_req = 1'b0;
        tick();
        check("drop_ack", 32'(a_ack), 32'd1);
        check("drop_rdata", 32'(a_rdata), 32'h0000BEEF);
        tick();

        // Simultaneous requests after reset: A first on the tie.
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'd26;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'd27; b_wdata = 16'h00AA;
        t0 = cyc;
        tick();
        check("tie_first_rd", 32'(mem_read), 32'd1);
        check("tie_first_addr", 32'(mem_addr), 32'd26);
        tick();
        check("tie_a_ack", 32'(a_ack), 32'd1);
        check("tie_b_noack", 32'(b_ack), 32'd0);
        check("tie_a_rdata", 32'(a_rdata), 32'h0000BEEF);
        check("tie_a_cycle", 32'(cyc - t0), 32'd2);
        tick();
        a_req = 1'b0;
        check("tie_b_wait", 32'(b_ack), 32'd0);
        tick();
        check("tie_b_wr", 32'(mem_write), 32'd1);
        check("tie_b_addr", 32'(mem_addr), 32'd27);
        check("tie_b_wdata", 32'(mem_wdata), 32'h000000AA);
        tick();
        check("tie_b_ack", 32'(b_ack), 32'd1);
        check("tie_b_cycle", 32'(cyc - t0), 32'd5);
        tick();
        b_req = 1'b0;

        // Starvation / alternation: A wants 4 writes, B wants 2 reads of 27.
        do_reset();
        a_left = 4; b_left = 2; ai = 0;
        b_we = 1'b0; b_addr = 16'd27;
        for (int r = 0; r < 6; r++) begin
            a_req = (a_left > 0);
            a_we = 1'b1; a_addr = 16'd100 + 16'(ai); a_wdata = 16'h1000 + 16'(ai);
            b_req = (b_left > 0);
            tick();
            check("st_wr", 32'(mem_write), 32'(!exp_w[r]));
            check("st_addr", 32'(mem_addr), exp_w[r] ? 32'd27 : 32'(16'd100 + 16'(ai)));
            tick();
            check("st_a_ack", 32'(a_ack), 32'(!exp_w[r]));
            check("st_b_ack", 32'(b_ack), 32'(exp_w[r]));
            if (exp_w[r]) check("st_b_rdata", 32'(b_rdata), 32'h000000AA);
            if (exp_w[r]) b_left--;
            else begin a_left--; ai++; end
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        txn(1'b0, 1'b0, 16'd103, 16'h0000, 16'h1003, "st_rdback");

        // Reset during ISSUE of a B read aborts without ack.
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'd27;
        tick();
        check("mid_issue", 32'(mem_read), 32'd1);
        resetn = 1'b0;
        tick();
        check("mid_noack", 32'(b_ack), 32'd0);
        check("mid_rdata", 32'(b_rdata), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_strobe", 32'(mem_read), 32'd0);
        b_req = 1'b0;
        tick();
        check("mid_still_noack", 32'(b_ack), 32'd0);
        resetn = 1'b1;
        txn(1'b1, 1'b0, 16'd27, 16'h0000, 16'h00AA, "mid_fresh");

        // Loader-style back-to-back B write/read at address 0.
        txn(1'b1, 1'b1, 16'd0, 16'h0327, 16'h0000, "ld_wr");
        t0 = last_ack_cyc;
        txn(1'b1, 1'b0, 16'd0, 16'h0000, 16'h0327, "ld_rd");
        check("ld_spacing", 32'(last_ack_cyc - t0), 32'd3);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
